// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated registered N:1 mux.
package arb_mux_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  // Select width: one bit minimum so a single-input mux still has a port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational grant picker: fixed priority or round-robin from ptr.
// With ARB_MUX_LOCK_EN defined, a held lock forces the grant to lock_idx.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUMBER   = 4,
  parameter arb_mode_e   MODE     = ARB_RR,
  parameter int unsigned SELECT_W = sel_width(NUMBER)
) (
  input  logic [NUMBER-1:0]   req,
  input  logic [SELECT_W-1:0] ptr,
`ifdef ARB_MUX_LOCK_EN
  input  logic                lock,
  input  logic [SELECT_W-1:0] lock_idx,
`endif
  output logic [SELECT_W-1:0] gnt_idx,
  output logic                gnt_any
);

  int unsigned start;
  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    start   = (MODE == ARB_RR) ? int'(ptr) : 0;
    for (int unsigned k = 0; k < NUMBER; k++) begin
      idx = (start + k) % NUMBER;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SELECT_W'(idx);
      end
    end
`ifdef ARB_MUX_LOCK_EN
    if (lock) begin
      gnt_idx = lock_idx;
      gnt_any = req[lock_idx];
    end
`endif
  end

endmodule

// File: rtl/arb_mux.sv
// Registered, arbitrated N:1 mux with valid/ready on every lane.
// Optional packet lock enabled by defining ARB_MUX_LOCK_EN.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUMBER   = 4,
  parameter arb_mode_e   MODE     = ARB_RR,
  localparam int unsigned SELECT_W = sel_width(NUMBER)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUMBER-1:0]   in_valid,
  output logic [NUMBER-1:0]   in_ready,
  input  logic [WIDTH-1:0]    in_data [NUMBER],
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUMBER-1:0]   in_last,
  output logic                out_last,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELECT_W-1:0] out_sel
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELECT_W-1:0] out_sel_q,   out_sel_d;
  logic [SELECT_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [SELECT_W-1:0] gnt_idx;
  logic                gnt_any;
  logic                load;
  logic                xfer;
  logic                adv_ptr;
`ifdef ARB_MUX_LOCK_EN
  logic                locked_q,   locked_d;
  logic [SELECT_W-1:0] lock_idx_q, lock_idx_d;
  logic                out_last_q, out_last_d;
`endif

  rr_pick #(
    .NUMBER   (NUMBER),
    .MODE     (MODE),
    .SELECT_W (SELECT_W)
  ) u_pick (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
`ifdef ARB_MUX_LOCK_EN
    .lock     (locked_q),
    .lock_idx (lock_idx_q),
`endif
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_any;

`ifdef ARB_MUX_LOCK_EN
  assign adv_ptr = xfer && in_last[gnt_idx];
`else
  assign adv_ptr = xfer;
`endif

  always_comb begin
    in_ready = '0;
    if (load && (|in_valid)) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output stage update and pointer advance; FIXED mode keeps the pointer at 0.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ARB_MUX_LOCK_EN
    locked_d    = locked_q;
    lock_idx_d  = lock_idx_q;
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = in_data[gnt_idx];
        out_sel_d  = gnt_idx;
`ifdef ARB_MUX_LOCK_EN
        out_last_d = in_last[gnt_idx];
        locked_d   = !in_last[gnt_idx];
        lock_idx_d = gnt_idx;
`endif
      end
    end
    if (adv_ptr && (MODE == ARB_RR)) begin
      rr_ptr_d = (gnt_idx == SELECT_W'(NUMBER - 1)) ? '0 : gnt_idx + SELECT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef ARB_MUX_LOCK_EN
      locked_q    <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
      locked_q    <= locked_d;
      lock_idx_q  <= lock_idx_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
